// File: rtl/manchester_serdes_if.sv
// Handshake, serial line and receive bus for manchester_serdes.
// The master side drives the payload, the accept enable and the receive line.
interface manchester_serdes_if #(
  parameter int WIDTH = 8
);
  logic             ena;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             line_out;
  logic             line_oe;
  logic             rx_line;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_err;

  modport master (
    output ena, tx_data, tx_valid, rx_line,
    input  tx_ready, line_out, line_oe, rx_data, rx_valid, rx_err
  );

  modport slave (
    input  ena, tx_data, tx_valid, rx_line,
    output tx_ready, line_out, line_oe, rx_data, rx_valid, rx_err
  );
endinterface

// File: rtl/manchester_serdes.sv
// Manchester serializer/deserializer framed by a high violation symbol and a low guard.
// Define MANCHESTER_PARITY_EN to append and check an even-parity bit after the payload.
module manchester_serdes #(
  parameter int WIDTH         = 8,
  parameter int CLKS_PER_HALF = 4,
  parameter int POLARITY      = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  manchester_serdes_if.slave bus
);
  localparam int CW = $clog2(2*CLKS_PER_HALF);
  localparam int HW = $clog2(CLKS_PER_HALF);
  localparam int BW = $clog2(WIDTH);
  localparam logic POL = (POLARITY != 0);
  localparam logic [CW-1:0] SYM_LAST  = CW'(2*CLKS_PER_HALF-1);
  localparam logic [CW-1:0] HALF_CNT  = CW'(CLKS_PER_HALF);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH-1);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF-1);
  localparam logic [HW-1:0] MID_WAIT  = HW'(CLKS_PER_HALF/2-1);

  localparam logic [2:0] TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_GUARD = 3'd4;
  localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_WAIT  = 3'd4;
`ifdef MANCHESTER_PARITY_EN
  localparam logic [2:0] TX_PAR = 3'd3, RX_PAR = 3'd3;
`endif

  // ---------------- transmitter ----------------
  logic [2:0]       tx_st_q, tx_st_d;
  logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]    tx_bit_q, tx_bit_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic             rdy_en_q;
  logic             tx_sym_end, tx_cur, tx_symbol;
`ifdef MANCHESTER_PARITY_EN
  logic             tx_par_q, tx_par_d;
  assign tx_cur    = (tx_st_q == TX_PAR) ? tx_par_q : tx_sh_q[WIDTH-1];
  assign tx_symbol = (tx_st_q == TX_DATA) || (tx_st_q == TX_PAR);
`else
  assign tx_cur    = tx_sh_q[WIDTH-1];
  assign tx_symbol = (tx_st_q == TX_DATA);
`endif

  assign tx_sym_end   = (tx_cnt_q == SYM_LAST);
  // rdy_en_q keeps tx_ready low until the first edge after reset release
  assign bus.tx_ready = (tx_st_q == TX_IDLE) && bus.ena && rdy_en_q;
  assign bus.line_oe  = (tx_st_q != TX_IDLE);
  assign bus.line_out = (tx_st_q == TX_START) ||
                        (tx_symbol && (tx_cur ^ ~POL ^ (tx_cnt_q >= HALF_CNT)));

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
`ifdef MANCHESTER_PARITY_EN
    tx_par_d = tx_par_q;
`endif
    if (tx_st_q != TX_IDLE) tx_cnt_d = tx_sym_end ? '0 : tx_cnt_q + 1'b1;
    case (tx_st_q)
      TX_IDLE: if (bus.tx_valid && bus.tx_ready) begin
        tx_st_d  = TX_START;
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_sh_d  = bus.tx_data;
`ifdef MANCHESTER_PARITY_EN
        tx_par_d = ^bus.tx_data;
`endif
      end
      TX_START: if (tx_sym_end) tx_st_d = TX_DATA;
      TX_DATA: if (tx_sym_end) begin
        tx_sh_d  = tx_sh_q << 1;
        tx_bit_d = tx_bit_q + 1'b1;
`ifdef MANCHESTER_PARITY_EN
        if (tx_bit_q == BIT_LAST) tx_st_d = TX_PAR;
`else
        if (tx_bit_q == BIT_LAST) tx_st_d = TX_GUARD;
`endif
      end
`ifdef MANCHESTER_PARITY_EN
      TX_PAR:   if (tx_sym_end) tx_st_d = TX_GUARD;
`endif
      TX_GUARD: if (tx_sym_end) tx_st_d = TX_IDLE;
      default:  tx_st_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q  <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      rdy_en_q <= 1'b0;
`ifdef MANCHESTER_PARITY_EN
      tx_par_q <= 1'b0;
`endif
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      rdy_en_q <= 1'b1;
`ifdef MANCHESTER_PARITY_EN
      tx_par_q <= tx_par_d;
`endif
    end
  end

  // ---------------- receiver ----------------
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic [2:0]       rx_st_q, rx_st_d;
  logic [HW-1:0]    rx_cnt_q, rx_cnt_d;
  logic             rx_half_q, rx_half_d, rx_first_q, rx_first_d;
  logic [BW-1:0]    rx_bit_q, rx_bit_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
  logic             rx_good, rx_fail, rx_dec;

  assign rx_dec       = rx_first_q ^ ~POL;  // bit value implied by the first half
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_err   = rx_err_q;

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_half_d  = rx_half_q;
    rx_first_d = rx_first_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    rx_good    = 1'b0;
    rx_fail    = 1'b0;
    case (rx_st_q)
      RX_IDLE: if (rx_s2_q && !rx_prev_q) begin
        rx_st_d   = RX_START;
        rx_cnt_d  = MID_WAIT;
        rx_half_d = 1'b0;
        rx_bit_d  = '0;
      end
`ifdef MANCHESTER_PARITY_EN
      RX_START, RX_DATA, RX_PAR: begin
`else
      RX_START, RX_DATA: begin
`endif
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else begin
          rx_cnt_d  = HALF_LAST;
          rx_half_d = ~rx_half_q;
          if (!rx_half_q) rx_first_d = rx_s2_q;
          else if (rx_st_q == RX_START) begin
            if (rx_first_q && rx_s2_q) rx_st_d = RX_DATA;
            else rx_fail = 1'b1;
          end else if (rx_first_q == rx_s2_q) rx_fail = 1'b1;
          else if (rx_st_q == RX_DATA) begin
            rx_sh_d  = {rx_sh_q[WIDTH-2:0], rx_dec};
            rx_bit_d = rx_bit_q + 1'b1;
`ifdef MANCHESTER_PARITY_EN
            if (rx_bit_q == BIT_LAST) rx_st_d = RX_PAR;
          end else if (rx_dec == ^rx_sh_q) rx_good = 1'b1;
          else rx_fail = 1'b1;
`else
            if (rx_bit_q == BIT_LAST) rx_good = 1'b1;
          end
`endif
        end
      end
      RX_WAIT: begin
        if (rx_s2_q) rx_cnt_d = '0;
        else if (rx_cnt_q == HALF_LAST) begin
          rx_st_d  = RX_IDLE;
          rx_cnt_d = '0;
        end else rx_cnt_d = rx_cnt_q + 1'b1;
      end
      default: rx_st_d = RX_IDLE;
    endcase
    if (rx_fail) begin
      rx_err_d = 1'b1;
      rx_st_d  = RX_WAIT;
      rx_cnt_d = '0;
    end else if (rx_good) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rx_sh_d;
      rx_st_d    = RX_WAIT;
      rx_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b0;
      rx_s2_q    <= 1'b0;
      rx_prev_q  <= 1'b0;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_half_q  <= 1'b0;
      rx_first_q <= 1'b0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_s1_q    <= bus.rx_line;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_half_q  <= rx_half_d;
      rx_first_q <= rx_first_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end
endmodule

// File: tb/tb_manchester_serdes.sv
// Loopback bench: a per-cycle waveform/receive model for the default instance,
// plus directed literal checks on both the default and the POLARITY=1 instance.
`timescale 1ns/1ps
module tb_manchester_serdes;
  localparam int W = 8, C = 4, SYM = 2*C;
`ifdef MANCHESTER_PARITY_EN
  localparam int NB = W + 2;
  localparam int FRAME_LEN = 88;
`else
  localparam int NB = W + 1;
  localparam int FRAME_LEN = 80;
`endif
  localparam int B3_LO = SYM*(1+W-1-3), B3_HI = B3_LO + SYM - 1;
  localparam int PB_LO = SYM*(1+W),     PB_HI = PB_LO + SYM - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  manchester_serdes_if #(.WIDTH(W)) if0 ();
  manchester_serdes_if #(.WIDTH(W)) if1 ();

  manchester_serdes #(.WIDTH(W), .CLKS_PER_HALF(C), .POLARITY(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  manchester_serdes #(.WIDTH(W), .CLKS_PER_HALF(C), .POLARITY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int start_cyc = -1000;
  int mode = 0;           // 0 loopback, 1 force bit 3 high then hold low, 2 invert parity bit
  int fp;
  int v0 = 0, e0 = 0, v1 = 0, e1 = 0;
  logic m_en;
  logic [1:0] lq[$];      // expected {line_oe, line_out} per cycle
  typedef struct { int cyc; bit err; logic [7:0] d; } ev_t;
  ev_t evq[$];
  logic [7:0] m_rxd;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_en <= 1'b0; else m_en <= 1'b1;

  always_comb begin
    fp = cyc - start_cyc;
    if0.rx_line = if0.line_out;
    if (mode == 1 && fp >= B3_LO) if0.rx_line = (fp <= B3_HI);
    if (mode == 2 && fp >= PB_LO && fp <= PB_HI) if0.rx_line = ~if0.line_out;
  end
  assign if1.rx_line = if1.line_out;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push_bit(input logic v);
    logic f;
    f = ~v;  // IEEE 802.3: a 1 is low then high
    repeat (C) lq.push_back({1'b1, f});
    repeat (C) lq.push_back({1'b1, ~f});
  endtask

  task automatic push_frame(input logic [7:0] d, input int s);
    start_cyc = s;
    repeat (SYM) lq.push_back(2'b11);
    for (int b = W-1; b >= 0; b--) push_bit(d[b]);
`ifdef MANCHESTER_PARITY_EN
    push_bit(^d);
`endif
    repeat (SYM) lq.push_back(2'b10);
    // rx sees the line two cycles late; samples at mid-half; result one cycle after sample k
    if (mode == 1) evq.push_back('{s + 3 + C/2 + (2*(1+W-1-3)+1)*C, 1'b1, d});
    else if (mode == 2) evq.push_back('{s + 3 + C/2 + (2*NB-1)*C, 1'b1, d});
    else evq.push_back('{s + 3 + C/2 + (2*NB-1)*C, 1'b0, d});
  endtask

  always @(negedge clk) begin
    logic erdy, eoe, eout, ev, ee;
    erdy = 0; eoe = 0; eout = 0; ev = 0; ee = 0;
    if (!rst_n) begin
      lq.delete(); evq.delete(); m_rxd = '0;
    end else begin
      erdy = m_en && if0.ena && (lq.size() == 0);
      if (lq.size() > 0) {eoe, eout} = lq[0];
      foreach (evq[i]) if (evq[i].cyc == cyc) begin
        if (evq[i].err) ee = 1'b1;
        else begin ev = 1'b1; m_rxd = evq[i].d; end
      end
    end
    chk("tx_ready", if0.tx_ready, erdy);
    chk("line_out", if0.line_out, eout);
    chk("line_oe", if0.line_oe, eoe);
    chk("rx_valid", if0.rx_valid, ev);
    chk("rx_err", if0.rx_err, ee);
    chk("rx_data", if0.rx_data, m_rxd);
    if (rst_n) begin
      if (lq.size() > 0) void'(lq.pop_front());
      if (erdy && if0.tx_valid) push_frame(if0.tx_data, cyc + 1);
    end
  end

  always @(negedge clk) begin
    if (if0.rx_valid) v0++;
    if (if0.rx_err) e0++;
    if (if1.rx_valid) v1++;
    if (if1.rx_err) e1++;
  end

  task automatic wait_ready0();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!if0.tx_ready && t < 400);
    if (!if0.tx_ready) begin n_chk++; $display("FAIL tx_ready0 timeout: got 0 expected 1"); end
  endtask

  task automatic send0(input logic [7:0] d);
    @(posedge clk); #1;
    if0.tx_data = d; if0.tx_valid = 1'b1;
    wait_ready0();
    @(posedge clk); #1;
    if0.tx_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d);
    int t;
    @(posedge clk); #1;
    if1.tx_data = d; if1.tx_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!if1.tx_ready && t < 400);
    if (!if1.tx_ready) begin n_chk++; $display("FAIL tx_ready1 timeout: got 0 expected 1"); end
    @(posedge clk); #1;
    if1.tx_valid = 1'b0;
  endtask

  initial begin
    int vb, eb, n;
    if0.ena = 1'b1; if0.tx_valid = 1'b0; if0.tx_data = '0;
    if1.ena = 1'b1; if1.tx_valid = 1'b0; if1.tx_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("ready_at_release", if0.tx_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_release", if0.tx_ready, 1);

    // 0xB2: violation then bit7 = low half + high half; ena drops mid-frame
    vb = v0; eb = e0;
    send0(8'hB2);
    for (int i = 0; i < 16; i++) begin
      chk("b2_wave", if0.line_out, (i < 8) ? 1 : (i < 12) ? 0 : 1);
      if (i == 10) if0.ena = 1'b0;
      @(posedge clk); #1;
    end
    repeat (70) @(posedge clk); #1;
    chk("b2_rx_data", if0.rx_data, 8'hB2);
    chk("b2_valid_pulses", v0 - vb, 1);
    chk("b2_err_pulses", e0 - eb, 0);

    // held tx_valid: blocked while ena=0, then back-to-back 0xF0, 0x0F
    vb = v0; eb = e0;
    if0.tx_data = 8'hF0; if0.tx_valid = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("ena0_no_frame", if0.line_oe, 0);
    if0.ena = 1'b1;
    wait_ready0();
    @(posedge clk); #1;
    if0.tx_data = 8'h0F;
    wait_ready0();
    @(posedge clk); #1;
    if0.tx_valid = 1'b0;
    repeat (100) @(posedge clk); #1;
    chk("hold_rx_data", if0.rx_data, 8'h0F);
    chk("hold_valid_pulses", v0 - vb, 2);
    chk("hold_err_pulses", e0 - eb, 0);

    // bit 3 forced high on both halves, line held low afterwards
    vb = v0; eb = e0;
    mode = 1;
    send0(8'hB2);
    repeat (100) @(posedge clk); #1;
    chk("force_err_pulses", e0 - eb, 1);
    chk("force_valid_pulses", v0 - vb, 0);
    chk("force_rx_data_kept", if0.rx_data, 8'h0F);
    mode = 0;

    // frame length from START entry to IDLE
    vb = v0;
    send0(8'hA5);
    n = 0;
    while (if0.line_oe && n < 200) begin n++; @(posedge clk); #1; end
    chk("frame_len", n, FRAME_LEN);
    repeat (20) @(posedge clk); #1;
    chk("a5_rx_data", if0.rx_data, 8'hA5);
    chk("a5_valid_pulses", v0 - vb, 1);

`ifdef MANCHESTER_PARITY_EN
    vb = v0; eb = e0;
    mode = 2;
    send0(8'hB2);
    repeat (100) @(posedge clk); #1;
    chk("par_err_pulses", e0 - eb, 1);
    chk("par_valid_pulses", v0 - vb, 0);
    chk("par_rx_data_kept", if0.rx_data, 8'hA5);
    mode = 0;
`endif

    // POLARITY=1: a 0 is low then high, a 1 is high then low
    vb = v1; eb = e1;
    send1(8'h0F);
    for (int i = 0; i < 48; i++) begin
      if (i >= 8 && i < 16) chk("pol1_bit7", if1.line_out, (i < 12) ? 0 : 1);
      if (i >= 40)          chk("pol1_bit3", if1.line_out, (i < 44) ? 1 : 0);
      @(posedge clk); #1;
    end
    repeat (60) @(posedge clk); #1;
    chk("pol1_rx_data", if1.rx_data, 8'h0F);
    chk("pol1_valid_pulses", v1 - vb, 1);
    chk("pol1_err_pulses", e1 - eb, 0);

    // reset in the middle of a frame
    vb = v0; eb = e0;
    send0(8'h3C);
    repeat (30) @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_line_out", if0.line_out, 0);
    chk("rst_line_oe", if0.line_oe, 0);
    chk("rst_tx_ready", if0.tx_ready, 0);
    chk("rst_rx_valid", if0.rx_valid, 0);
    chk("rst_rx_data", if0.rx_data, 0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_ready_at_release", if0.tx_ready, 0);
    @(posedge clk); #1;
    chk("rst_ready_after_release", if0.tx_ready, 1);
    repeat (100) @(posedge clk); #1;
    chk("rst_no_valid", v0 - vb, 0);
    chk("rst_no_err", e0 - eb, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
